// File: rtl/uart2bus_bin_pkg.sv
// uart2bus_bin_pkg: binary frame constants and FSM state encoding for uart2bus_bin_master
package uart2bus_bin_pkg;
  localparam logic [7:0] BIN_PREFIX  = 8'h00;
  localparam logic [7:0] CMD_READ    = 8'h11;
  localparam logic [7:0] CMD_WRITE   = 8'h21;
  localparam logic [7:0] BIN_LEN_ONE = 8'h01;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LOAD,
    ST_TX_GUARD,
    ST_TX_WAIT,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_RESP
  } state_t;
endpackage

// File: rtl/uart2bus_bin_timeout.sv
// uart2bus_bin_timeout: inter-byte watchdog (clock, reset active-low; clear, enable in; expired out, asserted on the cycle the count reaches TIMEOUT_CYCLES)
module uart2bus_bin_timeout #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  assign expired = enable && !clear && count == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart2bus_bin_master.sv
// uart2bus_bin_master: turns single-beat req_* requests into uart2bus binary frames on tx_*, parses rx_* reply into rsp_*
module uart2bus_bin_master
  import uart2bus_bin_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h5A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data
);
  state_t state, next_state;
  logic wr;
  logic [15:0] addr;
  logic [7:0] wdata, rx_byte;
  logic [2:0] idx;
  logic in_rx, expired, last_byte, ack_ok;
  assign in_rx = state == ST_RX_DATA || state == ST_RX_ACK;
  assign last_byte = idx == (wr ? 3'd6 : 3'd5);
  assign ack_ok = rx_data == ACK_BYTE;
  assign new_tx_data = state == ST_TX_LOAD && !tx_busy;
  assign rsp_valid = state == ST_RESP;
  assign tx_data = idx == 3'd0 ? BIN_PREFIX :
                   idx == 3'd1 ? (wr ? CMD_WRITE : CMD_READ) :
                   idx == 3'd2 ? addr[15:8] :
                   idx == 3'd3 ? addr[7:0] :
                   idx == 3'd4 ? BIN_LEN_ONE : wdata;
  // held clear outside the receive states so each RX phase starts from zero
  uart2bus_bin_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_rx || new_rx_data),
    .enable (in_rx),
    .expired(expired)
  );
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (req_valid && req_ready) next_state = ST_TX_LOAD;
      ST_TX_LOAD:  if (!tx_busy) next_state = ST_TX_GUARD;
      ST_TX_GUARD: next_state = ST_TX_WAIT;
      ST_TX_WAIT:  if (!tx_busy) next_state = !last_byte ? ST_TX_LOAD : wr ? ST_RX_ACK : ST_RX_DATA;
      ST_RX_DATA:  next_state = new_rx_data ? ST_RX_ACK : expired ? ST_RESP : ST_RX_DATA;
      ST_RX_ACK:   if (new_rx_data || expired) next_state = ST_RESP;
      ST_RESP:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rx_byte   <= '0;
      idx       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= next_state == ST_IDLE;
      if (req_valid && req_ready) begin
        wr    <= req_write;
        addr  <= req_addr;
        wdata <= req_wdata;
        idx   <= '0;
      end
      if (new_tx_data) idx <= idx + 3'd1;
      if (state == ST_RX_DATA && new_rx_data) rx_byte <= rx_data;
      // read data is published only once the ack confirms it
      if (state == ST_RX_ACK && new_rx_data) begin
        rsp_err <= !ack_ok;
        if (!wr && ack_ok) rsp_rdata <= rx_byte;
      end else if (in_rx && expired) rsp_err <= 1'b1;
    end
endmodule

// File: tb/tb_uart2bus_bin_master.sv
// tb_uart2bus_bin_master: table-driven scoreboard bench with a UART byte model
module tb_uart2bus_bin_master;
  localparam int TO = 50;
  localparam logic [7:0] ACK = 8'h5A;
  logic clock = 0, reset = 0, req_valid = 0, req_write = 0, tx_busy = 0, new_rx_data = 0;
  logic [15:0] req_addr = 0;
  logic [7:0] req_wdata = 0, rx_data = 0;
  logic req_ready, rsp_valid, rsp_err, new_tx_data;
  logic [7:0] rsp_rdata, tx_data;
  int checks = 0, passed = 0, ntx = 0, n_rsp = 0, busy_left = 0;
  bit hold_busy = 0;
  logic [7:0] last_rdata = 0;
  logic [7:0] exp_tx[$];
  typedef struct packed {logic err; logic [7:0] rdata;} rsp_t;
  rsp_t exp_rsp[$];
  typedef struct {
    logic wr; logic [15:0] addr; logic [7:0] wdata, rd, ack;
    logic send_data, send_ack, stall;
  } vec_t;
  vec_t vecs[9];

  always #5 clock = ~clock;

  uart2bus_bin_master #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(ACK)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .new_rx_data(new_rx_data)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // transmitter model: each load keeps tx_busy high for 3 cycles; bytes checked against the frame scoreboard
  initial begin
    logic s;
    logic [7:0] b;
    forever begin
      @(negedge clock);
      s = new_tx_data;
      b = tx_data;
      @(posedge clock);
      #1;
      if (s) begin
        ntx++;
        if (exp_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_extra: got byte %02h expected none", b);
        end else chk("tx_byte", b, exp_tx.pop_front());
        busy_left = 3;
      end
      tx_busy = hold_busy || busy_left > 0;
      if (busy_left > 0) busy_left--;
    end
  end

  // response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        n_rsp++;
        if (exp_rsp.size() == 0) begin
          checks++;
          $display("FAIL rsp_extra: got err=%0b rdata=%02h expected no response", rsp_err, rsp_rdata);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
    $fatal(1);
  end

  function automatic void push_frame(input logic wr, input logic [15:0] a, input logic [7:0] d);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(wr ? 8'h21 : 8'h11);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    exp_tx.push_back(8'h01);
    if (wr) exp_tx.push_back(d);
  endfunction

  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready", req_ready, 1);
    @(posedge clock);
    #1;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clock);
    #1;
    req_valid = 0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_data = b; new_rx_data = 1;
    @(posedge clock);
    #1;
    new_rx_data = 0;
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("tx_drain", exp_tx.size(), 0);
    repeat (8) @(posedge clock);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (n < 500) begin
      @(negedge clock);
      if (rsp_valid) break;
      n++;
    end
    chk("rsp_seen", rsp_valid, 1);
    chk("ready_during_rsp", req_ready, 0);
    @(negedge clock);
    chk("rsp_pulse", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
  endtask

  task automatic do_txn(input vec_t v);
    rsp_t e;
    int n, base;
    push_frame(v.wr, v.addr, v.wdata);
    e.err = !(v.send_ack && v.ack == ACK);
    e.rdata = (!v.wr && v.send_data && !e.err) ? v.rd : last_rdata;
    last_rdata = e.rdata;
    exp_rsp.push_back(e);
    base = ntx;
    issue(v.wr, v.addr, v.wdata);
    if (v.stall) begin
      n = 0;
      while (ntx - base < 2 && n < 200) begin
        @(negedge clock);
        n++;
      end
      chk("stall_reach", ntx - base, 2);
      hold_busy = 1;
      send_rx(8'hEE);
      repeat (1000) @(posedge clock);
      chk("stall_ntx", ntx - base, 2);
      hold_busy = 0;
    end
    wait_tx_done();
    if (!v.wr && v.send_data) begin
      send_rx(v.rd);
      if (v.send_ack) repeat (3) @(posedge clock);
    end
    if (v.send_ack) send_rx(v.ack);
    wait_rsp(n);
    if (!v.send_ack && v.send_data) chk("timeout_cycles", n, TO);
  endtask

  initial begin
    int base, nr;
    vecs[0] = '{1, 16'h1234, 8'hA5, 8'h00, ACK,   0, 1, 0};
    vecs[1] = '{0, 16'h0007, 8'h00, 8'h3C, ACK,   1, 1, 0};
    vecs[2] = '{1, 16'h00FF, 8'h3C, 8'h00, 8'h00, 0, 1, 0};
    vecs[3] = '{0, 16'hABCD, 8'h00, 8'h11, ACK,   1, 0, 0};
    vecs[4] = '{0, 16'hFFFF, 8'h00, 8'hC3, ACK,   1, 1, 0};
    vecs[5] = '{0, 16'h0100, 8'h00, 8'h55, 8'h5B, 1, 1, 0};
    vecs[6] = '{1, 16'hFFFF, 8'h00, 8'h00, ACK,   0, 1, 0};
    vecs[7] = '{0, 16'h0042, 8'h00, 8'h77, ACK,   1, 1, 1};
    vecs[8] = '{1, 16'h8000, 8'hFF, 8'h00, ACK,   0, 0, 0};
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_new_tx_data", new_tx_data, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    chk("ready_first_cycle", req_ready, 1);
    for (int i = 0; i < 9; i++) do_txn(vecs[i]);
    chk("rsp_count", n_rsp, 9);
    base = ntx;
    push_frame(1, 16'hBEEF, 8'h11);
    issue(1, 16'hBEEF, 8'h11);
    nr = 0;
    while (ntx - base < 4 && nr < 200) begin
      @(negedge clock);
      nr++;
    end
    chk("rst_reach", ntx - base, 4);
    nr = n_rsp;
    reset = 0;
    #1;
    chk("mid_req_ready", req_ready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_rdata", rsp_rdata, 0);
    chk("mid_rsp_err", rsp_err, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_new_tx_data", new_tx_data, 0);
    exp_tx.delete();
    last_rdata = 0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1;
    repeat (20) @(posedge clock);
    chk("mid_no_rsp", n_rsp, nr);
    do_txn('{1, 16'h5678, 8'h3E, 8'h00, ACK, 0, 1, 0});
    repeat (5) @(posedge clock);
    chk("final_rsp_count", n_rsp, 10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart2bus_bin_master.md
Name: uart2bus_bin_master

Overview:
- Host-side initiator for the uart2bus binary protocol: converts single-beat bus requests into binary command frames and parses the slave's reply.
- Sits between a local requester (CPU or sequencer) and a byte-level UART core (uart_tx/uart_rx with baud generator).
- Lets one FPGA drive a remote uart2bus_top over a serial link.

Parameters:
- TIMEOUT_CYCLES, 2000000, clocks allowed between consecutive received bytes before aborting. Must be >= 1. Counter width is $clog2(TIMEOUT_CYCLES+1).
- ACK_BYTE, 8'h5A, value the slave returns to acknowledge a command.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request pending.
- req_ready, output, 1, high in IDLE only; a transfer occurs when req_valid and req_ready are both high.
- req_write, input, 1, 1 = write, 0 = read.
- req_addr, input, 16, remote register address.
- req_wdata, input, 8, write data.
- rsp_valid, output, 1, one-cycle pulse when the transaction ends.
- rsp_rdata, output, 8, read data; valid with rsp_valid on a successful read.
- rsp_err, output, 1, qualified by rsp_valid: timeout or bad ack.
- tx_data, output, 8, byte to the UART transmitter.
- new_tx_data, output, 1, one-cycle load strobe to the transmitter.
- tx_busy, input, 1, transmitter busy.
- rx_data, input, 8, byte from the UART receiver.
- new_rx_data, input, 1, one-cycle strobe; rx_data is valid with it.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, tx_data=0, new_tx_data=0. req_ready rises in the first cycle after reset deasserts. The FSM is forced to IDLE.
- On handshake, latch write/addr/wdata and clear the byte index.
- Frame, MSB-first address:
  - byte0 = 8'h00 (binary prefix);
  - byte1 = command: 8'h11 read, 8'h21 write (bits[5:4] = cmd, bit0 = ack request, auto-increment irrelevant);
  - byte2 = addr[15:8];
  - byte3 = addr[7:0];
  - byte4 = 8'h01 (length);
  - byte5 = wdata, writes only.
  - Frame length: 5 bytes for a read, 6 for a write.
- FSM states:
  - IDLE: req_ready=1.
  - TX_LOAD: when tx_busy=0, drive tx_data and pulse new_tx_data for one cycle, then go to TX_GUARD.
  - TX_GUARD: one cycle with tx_busy ignored; covers the transmitter's one-cycle busy latency. Then go to TX_WAIT.
  - TX_WAIT: wait for tx_busy=0. Then go to TX_LOAD for the next byte, or to RX_DATA (read) / RX_ACK (write) after the last byte.
  - RX_DATA: on new_rx_data, capture rx_data and go to RX_ACK.
  - RX_ACK: on new_rx_data, if rx_data==ACK_BYTE, finish ok; otherwise finish with rsp_err=1.
  - RESP: pulse rsp_valid for one cycle, then go to IDLE.
- Timeout:
  - The counter clears on entry to RX_DATA/RX_ACK and on every new_rx_data; it increments each cycle otherwise.
  - Reaching TIMEOUT_CYCLES goes to RESP with rsp_err=1. On a read, rsp_rdata holds the previous value.
  - If new_rx_data and the timeout occur in the same cycle, the byte wins.
- new_rx_data outside RX_DATA/RX_ACK is ignored and discarded; stray bytes never corrupt the next transaction.
- rsp_rdata and rsp_err hold their value until the next RESP.
- The TX phase has no timeout: a stuck tx_busy stalls the block. This is intentional.
- req_valid while not in IDLE is ignored; req_ready=0.
- Reset asserted mid-frame aborts immediately with no rsp_valid. The remote slave recovers through its own 0x00 resync.

Decomposition:
- Package uart2bus_bin_pkg:
  - BIN_PREFIX=8'h00, CMD_READ=8'h11, CMD_WRITE=8'h21, BIN_LEN_ONE=8'h01;
  - state encoding for the 7 FSM states.
- One sub-module, uart2bus_bin_timeout: loadable inter-byte watchdog.
  - Ports: clock, reset, clear, enable, expired.
  - Parameter: TIMEOUT_CYCLES.
- The frame byte mux stays inline in the top module.

Test Plan:
- Write addr 16'h1234, data 8'hA5; UART model returns 8'h5A -> tx bytes 00 21 12 34 01 A5 in order; one rsp_valid pulse with rsp_err=0.
- Read addr 16'h0007; model returns 8'h3C then 8'h5A -> tx bytes 00 11 00 07 01; rsp_rdata=8'h3C, rsp_err=0; req_ready back high the cycle after rsp_valid.
- Write; model returns 8'h00 instead of the ack -> rsp_valid with rsp_err=1.
- TIMEOUT_CYCLES=50; read; model sends only the data byte -> rsp_err=1 exactly 50 cycles after that byte; rsp_rdata unchanged from the previous read.
- tx_busy held high for 1000 cycles during byte2 -> new_tx_data count stays at 2 until tx_busy drops. A stray new_rx_data strobe during TX is ignored: the next read still returns the correct data.
- Reset pulsed low while byte3 is in flight -> all outputs return to reset values immediately; no rsp_valid; a subsequent write completes normally.
